// File: rtl/pc_seq_pkg.sv
// Purpose: shared op encodings and widths for the PC sequencer.
// Latency: n/a (constants only).
// Backpressure: n/a.
package pc_seq_pkg;

    localparam int OP_W = 3;

    // Encodings 5..7 are reserved and behave as HOLD.
    typedef enum logic [OP_W-1:0] {
        OP_NEXT   = 3'd0,
        OP_BRANCH = 3'd1,
        OP_JUMP   = 3'd2,
        OP_CALL   = 3'd3,
        OP_RET    = 3'd4
    } op_e;

endpackage

// File: rtl/ras_stack.sv
// Purpose: LIFO return-address stack with occupancy count.
// Latency: push/pop visible on top/depth one clock after the sampling edge.
// Backpressure: none; caller must not push when full or pop when empty.
module ras_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         push_dat,
    output logic [WIDTH-1:0]         top,
    output logic [$clog2(DEPTH):0]   depth,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int DW = AW + 1;
    localparam logic [DW-1:0] CNT_ONE  = DW'(1);
    localparam logic [DW-1:0] CNT_FULL = DW'(DEPTH);
    localparam logic [AW-1:0] IDX_ONE  = AW'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [DW-1:0]    depth_q;
    logic [DW-1:0]    depth_d;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    rd_idx;

    // Next slot is indexed by the count; the top sits one below it.
    // When full the low bits wrap to 0, so rd_idx still lands on DEPTH-1.
    assign wr_idx = depth_q[AW-1:0];
    assign rd_idx = depth_q[AW-1:0] - IDX_ONE;

    assign top   = mem_q[rd_idx];
    assign depth = depth_q;
    assign full  = (depth_q == CNT_FULL);
    assign empty = (depth_q == '0);

    // Next-state for storage and occupancy; guards keep the count in range.
    always_comb begin
        mem_d   = mem_q;
        depth_d = depth_q;
        if (push && !full) begin
            mem_d[wr_idx] = push_dat;
            depth_d       = depth_q + CNT_ONE;
        end else if (pop && !empty) begin
            depth_d = depth_q - CNT_ONE;
        end
    end

    // Storage carries no reset; entries above depth are never read out.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    // Occupancy register; clearing it discards every stacked return.
    always_ff @(posedge clock) begin
        if (!reset) begin
            depth_q <= '0;
        end else begin
            depth_q <= depth_d;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Purpose: program counter with branch/jump/call/return and sticky stack error flags.
// Latency: every op lands on pc one clock after the sampling edge.
// Backpressure: none; en=0 freezes all state for that cycle.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int INC       = 2,
    parameter int RESET_VEC = 0,
    parameter int DEPTH     = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     en,
    input  logic [OP_W-1:0]          op,
    input  logic [WIDTH-1:0]         target,
    input  logic [WIDTH-1:0]         offset,
    output logic [WIDTH-1:0]         pc,
    output logic [$clog2(DEPTH):0]   depth,
    output logic                     overflow,
    output logic                     underflow
);

    localparam logic [WIDTH-1:0] INC_V   = WIDTH'(INC);
    localparam logic [WIDTH-1:0] RESET_V = WIDTH'(RESET_VEC);

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_d;
    logic             overflow_q;
    logic             overflow_d;
    logic             underflow_q;
    logic             underflow_d;

    logic [WIDTH-1:0] pc_seq;
    logic [WIDTH-1:0] ras_top;
    logic             ras_push;
    logic             ras_pop;
    logic             ras_full;
    logic             ras_empty;

    // Sequential address doubles as the CALL return address; carry drops out.
    assign pc_seq = pc_q + INC_V;

    ras_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ras (
        .clock    (clock),
        .reset    (reset),
        .push     (ras_push),
        .pop      (ras_pop),
        .push_dat (pc_seq),
        .top      (ras_top),
        .depth    (depth),
        .full     (ras_full),
        .empty    (ras_empty)
    );

    // Op decode: next pc, stack requests and sticky error detection.
    always_comb begin
        pc_d        = pc_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        ras_push    = 1'b0;
        ras_pop     = 1'b0;
        if (en) begin
            case (op)
                OP_NEXT:   pc_d = pc_seq;
                OP_BRANCH: pc_d = pc_q + offset;
                OP_JUMP:   pc_d = target;
                OP_CALL: begin
                    // Jump still happens on overflow; only the push is dropped.
                    pc_d = target;
                    if (ras_full) begin
                        overflow_d = 1'b1;
                    end else begin
                        ras_push = 1'b1;
                    end
                end
                OP_RET: begin
                    // Empty-stack return falls through sequentially.
                    if (ras_empty) begin
                        pc_d        = pc_seq;
                        underflow_d = 1'b1;
                    end else begin
                        pc_d    = ras_top;
                        ras_pop = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // PC and sticky flag registers; reset wins over any op.
    always_ff @(posedge clock) begin
        if (!reset) begin
            pc_q        <= RESET_V;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign pc        = pc_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter WIDTH, default 16, bit width of PC, target and offset.
REQ-002 Parameter INC, default 2, sequential increment added to PC per NEXT.
REQ-003 Parameter RESET_VEC, default 0, PC value loaded by reset.
REQ-004 Parameter DEPTH, default 4, return-address-stack entries (power of two, >=2).
REQ-005 clock  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-low reset.
REQ-007 en  input  1  1 = apply op this cycle; 0 = hold all state.
REQ-008 op  input  3  operation select, encodings in shared package.
REQ-009 target  input  WIDTH  absolute address for JUMP and CALL.
REQ-010 offset  input  WIDTH  two's-complement displacement for BRANCH.
REQ-011 pc  output  WIDTH  current program counter, registered.
REQ-012 depth  output  clog2(DEPTH)+1  number of valid stack entries.
REQ-013 overflow  output  1  sticky, CALL attempted with stack full.
REQ-014 underflow  output  1  sticky, RET attempted with stack empty.

Function
REQ-015 Ops: NEXT=0 pc<=pc+INC; BRANCH=1 pc<=pc+offset; JUMP=2 pc<=target; CALL=3 push pc+INC, pc<=target; RET=4 pc<=popped entry; HOLD=5..7 no change.
REQ-016 All updates take effect one clock after the sampling edge; pc is never combinationally driven from inputs.
REQ-017 With en=0 pc, stack, depth and flags hold regardless of op.
REQ-018 All PC arithmetic is modulo 2^WIDTH; carry discarded (e.g. 16'hFFFE+2 -> 16'h0000).
REQ-019 BRANCH offset is sign-interpreted; offset 16'hFFFC subtracts 4.
REQ-020 CALL with depth<DEPTH: push pc+INC (mod 2^WIDTH) on top, depth+1, pc<=target.
REQ-021 CALL with depth==DEPTH: push suppressed, stack and depth unchanged, overflow<=1, pc<=target.
REQ-022 RET with depth>0: pc<=top entry, depth-1.
REQ-023 RET with depth==0: pc<=pc+INC, underflow<=1, depth stays 0.
REQ-024 Stack is LIFO: nested CALLs return in reverse order.
REQ-025 overflow and underflow, once set, remain 1 until reset.
REQ-026 Stack contents beyond depth are don't-care and never observable on pc.

Reset
REQ-027 reset=0 at a rising edge: pc<=RESET_VEC, depth<=0, overflow<=0, underflow<=0, regardless of en/op.
REQ-028 Reset has priority over every op; reset mid-call-sequence discards all stacked returns.
REQ-029 First op after reset release is applied at the first rising edge with reset=1.
REQ-030 Stack storage array needs no reset; only pointer/depth is reset.

Structure
REQ-031 Op encodings (NEXT, BRANCH, JUMP, CALL, RET) live as named constants in shared package pc_seq_pkg.
REQ-032 Return stack is one sub-module, ras_stack, parametrised by WIDTH and DEPTH, with push, pop, top, depth, full, empty.
REQ-033 pc_sequencer owns the PC register, op decode, adder and sticky flags.

Verification
REQ-034 Reset then en=1 op=NEXT for 5 cycles -> pc 0,2,4,6,8,10 (WIDTH=16, INC=2).
REQ-035 pc=16'h0010, BRANCH offset=16'hFFFC -> pc=16'h000C; pc=16'hFFFE, NEXT -> pc=16'h0000.
REQ-036 pc=0x20: CALL 0x100, CALL 0x200, RET, RET -> pc 0x100, 0x200, 0x102, 0x22; depth 1,2,1,0.
REQ-037 DEPTH=4: 5 consecutive CALLs -> depth=4, overflow=1 after 5th, pc=5th target; 4 RETs unwind correctly.
REQ-038 depth=0, pc=0x40, RET -> pc=0x42, underflow=1; en=0 with op=JUMP -> pc unchanged.
REQ-039 reset asserted with depth=3 and both flags set -> next cycle pc=RESET_VEC, depth=0, flags 0.
